uart_rx_param: RTL

Parametrised successor to the fixed 8N1 UART receiver. Supports configurable data width, parity mode, stop-bit count and bit period. Adds a 2-FF input synchroniser, 3-sample majority voting, false-start rejection, and parity, framing and break flags. Sits on the serial RX pin and feeds received words into the FFT capture/control path.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Serial receive bundle: the RX line in, the received word and its status flags out.
// The slave modport is the receiver's side and the master modport is the line driver's side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_bit;
  logic [DATA_BITS-1:0] o_Received_byte;
  logic                 o_valid;
  logic                 o_receive_state;
  logic                 o_parity_err;
  logic                 o_error;
  logic                 o_break;

  modport master (
    output i_RX_bit,
    input  o_Received_byte, o_valid, o_receive_state, o_parity_err, o_error, o_break
  );

  modport slave (
    input  i_RX_bit,
    output o_Received_byte, o_valid, o_receive_state, o_parity_err, o_error, o_break
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a 2-FF synchroniser, 3-sample majority vote and false-start rejection.
// It reports parity, framing and break status together with each received word.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_rx_param_if.slave bus
);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_END  = 4'(DATA_BITS);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  logic [1:0] sync_reg;
  logic [1:0] sync_in;
  logic       rx_s;

  assign sync_in = {sync_reg[0], bus.i_RX_bit};
  assign rx_s    = sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) sync_reg[gi] <= 1'b1;
        else          sync_reg[gi] <= sync_in[gi];
      end
    end
  endgenerate

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic [1:0]           samp_reg, samp_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 perr_flag_reg, perr_flag_next;
  logic                 ferr_flag_reg, ferr_flag_next;
  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 valid_reg, valid_next;
  logic                 perr_out_reg, perr_out_next;
  logic                 ferr_out_reg, ferr_out_next;
  logic                 brk_out_reg, brk_out_next;

  logic             cnt_wrap;
  logic             decide;
  logic             maj;
  logic             ferr_final;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_wrap = (cnt_reg == CNT_LAST);
  assign decide   = (cnt_reg == CNT_DEC);
  assign cnt_inc  = cnt_wrap ? '0 : cnt_reg + 1'b1;
  // Two samples were latched earlier in the bit; the third one is the live line.
  assign maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      samp_reg      <= '0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      perr_flag_reg <= 1'b0;
      ferr_flag_reg <= 1'b0;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      perr_out_reg  <= 1'b0;
      ferr_out_reg  <= 1'b0;
      brk_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      samp_reg      <= samp_next;
      shift_reg     <= shift_next;
      par_bit_reg   <= par_bit_next;
      perr_flag_reg <= perr_flag_next;
      ferr_flag_reg <= ferr_flag_next;
      data_out_reg  <= data_out_next;
      valid_reg     <= valid_next;
      perr_out_reg  <= perr_out_next;
      ferr_out_reg  <= ferr_out_next;
      brk_out_reg   <= brk_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    samp_next      = samp_reg;
    shift_next     = shift_reg;
    par_bit_next   = par_bit_reg;
    perr_flag_next = perr_flag_reg;
    ferr_flag_next = ferr_flag_reg;
    data_out_next  = data_out_reg;
    valid_next     = 1'b0;
    perr_out_next  = perr_out_reg;
    ferr_out_next  = ferr_out_reg;
    brk_out_next   = brk_out_reg;
    ferr_final     = 1'b0;

    if (cnt_reg == CNT_S0) samp_next[0] = rx_s;
    if (cnt_reg == CNT_S1) samp_next[1] = rx_s;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // The detecting cycle already counts as cycle 0 of the start bit.
        if (!rx_s) begin
          state_next = START;
          cnt_next   = CNT_W'(1);
        end
      end
      START: begin
        cnt_next = cnt_inc;
        if (decide && maj) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_wrap) begin
          state_next     = DATA;
          bit_idx_next   = '0;
          perr_flag_next = 1'b0;
          ferr_flag_next = 1'b0;
        end
      end
      DATA: begin
        cnt_next = cnt_inc;
        if (decide) begin
          shift_next   = {maj, shift_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 4'd1;
        end
        if (cnt_wrap && bit_idx_reg == DATA_END) begin
          state_next   = HAS_PARITY ? PARITY : STOP;
          bit_idx_next = '0;
        end
      end
      PARITY: begin
        cnt_next = cnt_inc;
        if (decide) begin
          par_bit_next   = maj;
          perr_flag_next = (PARITY_MODE == 1) ? ~(^shift_reg ^ maj) : (^shift_reg ^ maj);
        end
        if (cnt_wrap) begin
          state_next   = STOP;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        cnt_next = cnt_inc;
        if (decide) begin
          ferr_final = ferr_flag_reg | ~maj;
          if (bit_idx_reg == STOP_LAST) begin
            // Leave mid-bit so a back-to-back start edge is caught from IDLE.
            valid_next    = 1'b1;
            data_out_next = shift_reg;
            perr_out_next = perr_flag_reg;
            ferr_out_next = ferr_final;
            brk_out_next  = ferr_final && (shift_reg == '0) && !(HAS_PARITY && par_bit_reg);
            state_next    = ferr_final ? WAIT_IDLE : IDLE;
            cnt_next      = '0;
          end else begin
            ferr_flag_next = ferr_final;
            bit_idx_next   = bit_idx_reg + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_Received_byte = data_out_reg;
  assign bus.o_valid         = valid_reg;
  assign bus.o_parity_err    = perr_out_reg;
  assign bus.o_error         = ferr_out_reg;
  assign bus.o_break         = brk_out_reg;
  assign bus.o_receive_state = (state_reg == START) || (state_reg == DATA) ||
                               (state_reg == PARITY) || (state_reg == STOP);
endmodule
